// File: rtl/mmm_rj_seq_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmm_rj_seq_reg                                                           |
// | Montgomery multiplier partial-result register with iteration counter and |
// | start/done/ack handshake towards the exponentiation controller.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mmm_rj_seq_reg #(
   parameter int WIDTH = 10,
   parameter int SHIFT = 1,
   parameter int ITER  = 10,
   parameter int CNT_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   start,
   input  logic [WIDTH+SHIFT-1:0] rjo,
   input  logic                   ack,
   output logic [WIDTH-1:0]       reg_rji,
   output logic [CNT_W-1:0]       iter_cnt,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] reg_rji_q, reg_rji_d;
   logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Low SHIFT bits of the adder output are retired each iteration.
   logic rjo_low_unused;
   assign rjo_low_unused = ^rjo[SHIFT-1:0];

   always_comb begin
      state_d    = state_q;
      reg_rji_d  = reg_rji_q;
      iter_cnt_d = iter_cnt_q;
      if (en) begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d    = S_RUN;
                  reg_rji_d  = '0;
                  iter_cnt_d = '0;
               end
            end
            S_RUN: begin
               if (start) begin
                  reg_rji_d  = '0;
                  iter_cnt_d = '0;
               end else begin
                  reg_rji_d  = rjo[WIDTH+SHIFT-1:SHIFT];
                  iter_cnt_d = iter_cnt_q + CNT_W'(1);
                  if (iter_cnt_q == ITER_LAST) begin
                     state_d = S_DONE;
                  end
               end
            end
            S_DONE: begin
               // A new start takes precedence over acknowledging the old result.
               if (start) begin
                  state_d    = S_RUN;
                  reg_rji_d  = '0;
                  iter_cnt_d = '0;
               end else if (ack) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d    = S_IDLE;
               reg_rji_d  = '0;
               iter_cnt_d = '0;
            end
         endcase
      end
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         reg_rji_q  <= '0;
         iter_cnt_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         reg_rji_q  <= reg_rji_d;
         iter_cnt_q <= iter_cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign reg_rji  = reg_rji_q;
   assign iter_cnt = iter_cnt_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mmm_rj_seq_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mmm_rj_seq_reg                                                        |
// | Self-checking bench: radix-2 instance against a behavioural model, plus  |
// | a radix-4 instance for the wider shift.                                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mmm_rj_seq_reg;

   logic        clk;
   logic        rst, en, start, ack;
   logic [10:0] rjo;
   logic [9:0]  reg_rji;
   logic [3:0]  iter_cnt;
   logic        busy, done;

   logic        rst_b, en_b, start_b, ack_b;
   logic [9:0]  rjo_b;
   logic [7:0]  reg_b;
   logic [2:0]  cnt_b;
   logic        busy_b, done_b;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: phase 0 = idle, 1 = running, 2 = result ready.
   int          m_phase;
   int          m_cnt;
   logic [9:0]  m_res;

   mmm_rj_seq_reg #(.WIDTH(10), .SHIFT(1), .ITER(10), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst), .en(en), .start(start), .rjo(rjo), .ack(ack),
      .reg_rji(reg_rji), .iter_cnt(iter_cnt), .busy(busy), .done(done)
   );

   mmm_rj_seq_reg #(.WIDTH(8), .SHIFT(2), .ITER(4), .CNT_W(3)) dut_b (
      .clk(clk), .rst(rst_b), .en(en_b), .start(start_b), .rjo(rjo_b), .ack(ack_b),
      .reg_rji(reg_b), .iter_cnt(cnt_b), .busy(busy_b), .done(done_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Start beats everything; a run retires one rjo>>1 per enabled edge.
   function automatic void model_update();
      if (rst) begin
         m_phase = 0; m_cnt = 0; m_res = '0;
      end else if (en) begin
         if (start) begin
            m_phase = 1; m_cnt = 0; m_res = '0;
         end else if (m_phase == 1) begin
            m_res = 10'(rjo >> 1);
            m_cnt = m_cnt + 1;
            if (m_cnt == 10) m_phase = 2;
         end else if (m_phase == 2 && ack) begin
            m_phase = 0;
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; start = 1'b1; ack = 1'b0; rjo = '1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks += 4;
         if (reg_rji !== 10'h000) $display("FAIL reset_reg got %h want 000", reg_rji); else n_pass++;
         if (iter_cnt !== 4'd0)   $display("FAIL reset_cnt got %0d want 0", iter_cnt); else n_pass++;
         if (busy !== 1'b0)       $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
         if (done !== 1'b0)       $display("FAIL reset_done got %b want 0", done); else n_pass++;
      end
      rst = 1'b0; start = 1'b0; rjo = '0;
   endtask

   task automatic test_full_run();
      start = 1'b1; tick(); start = 1'b0;
      n_checks += 2;
      if (busy !== 1'b1)     $display("FAIL run_busy_after_start got %b want 1", busy); else n_pass++;
      if (iter_cnt !== 4'd0) $display("FAIL run_cnt_after_start got %0d want 0", iter_cnt); else n_pass++;
      rjo = 11'h7FE;
      for (int i = 1; i <= 10; i++) begin
         tick();
         n_checks += 3;
         if (reg_rji !== 10'h3FF)       $display("FAIL run_reg it%0d got %h want 3ff", i, reg_rji); else n_pass++;
         if (iter_cnt !== 4'(i))        $display("FAIL run_cnt it%0d got %0d want %0d", i, iter_cnt, i); else n_pass++;
         if (done !== (i == 10))        $display("FAIL run_done it%0d got %b want %b", i, done, i == 10); else n_pass++;
      end
      // DONE holds result and counter saturates even with rjo changing.
      rjo = 11'h155;
      tick(); tick();
      n_checks += 3;
      if (iter_cnt !== 4'd10) $display("FAIL done_cnt_sat got %0d want 10", iter_cnt); else n_pass++;
      if (reg_rji !== 10'h3FF) $display("FAIL done_reg_hold got %h want 3ff", reg_rji); else n_pass++;
      if (done !== 1'b1 || busy !== 1'b0) $display("FAIL done_flags got d%b b%b want d1 b0", done, busy); else n_pass++;
      ack = 1'b1; tick(); ack = 1'b0;
   endtask

   task automatic test_en_stall();
      int k;
      int done_at;
      done_at = -1;
      start = 1'b1; tick(); start = 1'b0;
      for (k = 1; k <= 40 && done_at < 0; k++) begin
         en = !(k >= 5 && k <= 7);
         start = !en; ack = !en;
         rjo = 11'($urandom);
         tick();
         if (k >= 5 && k <= 7) begin
            n_checks += 2;
            if (iter_cnt !== 4'd4) $display("FAIL stall_cnt k%0d got %0d want 4", k, iter_cnt); else n_pass++;
            if (busy !== 1'b1)     $display("FAIL stall_busy k%0d got %b want 1", k, busy); else n_pass++;
         end
         n_checks++;
         if (reg_rji !== m_res) $display("FAIL stall_reg k%0d got %h want %h", k, reg_rji, m_res); else n_pass++;
         if (done) done_at = k;
      end
      en = 1'b1; start = 1'b0; ack = 1'b0;
      n_checks++;
      if (done_at != 13) $display("FAIL stall_done_edge got %0d want 13", done_at); else n_pass++;
      ack = 1'b1; tick(); ack = 1'b0;
   endtask

   task automatic test_restart();
      int done_at;
      done_at = -1;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 7; i++) begin rjo = 11'($urandom); tick(); end
      start = 1'b1; rjo = 11'h7FF; tick(); start = 1'b0;
      n_checks += 3;
      if (reg_rji !== 10'h000) $display("FAIL restart_reg got %h want 000", reg_rji); else n_pass++;
      if (iter_cnt !== 4'd0)   $display("FAIL restart_cnt got %0d want 0", iter_cnt); else n_pass++;
      if (busy !== 1'b1)       $display("FAIL restart_busy got %b want 1", busy); else n_pass++;
      for (int i = 1; i <= 20 && done_at < 0; i++) begin
         rjo = 11'($urandom); ack = 1'($urandom);
         tick();
         if (done) done_at = i;
      end
      ack = 1'b0;
      n_checks += 2;
      if (done_at != 10)    $display("FAIL restart_done_edge got %0d want 10", done_at); else n_pass++;
      if (reg_rji !== m_res) $display("FAIL restart_final_reg got %h want %h", reg_rji, m_res); else n_pass++;
   endtask

   task automatic test_ack();
      logic [9:0] kept;
      kept = m_res;
      ack = 1'b1; tick(); ack = 1'b0;
      n_checks += 4;
      if (done !== 1'b0 || busy !== 1'b0) $display("FAIL ack_idle got d%b b%b want d0 b0", done, busy); else n_pass++;
      if (reg_rji !== kept)   $display("FAIL ack_reg_kept got %h want %h", reg_rji, kept); else n_pass++;
      if (iter_cnt !== 4'd10) $display("FAIL ack_cnt_kept got %0d want 10", iter_cnt); else n_pass++;
      tick();
      if (reg_rji !== kept)   $display("FAIL idle_hold got %h want %h", reg_rji, kept); else n_pass++;
      start = 1'b1; tick(); start = 1'b0;
      rjo = 11'h2AB;
      for (int i = 0; i < 10; i++) tick();
      n_checks++;
      if (done !== 1'b1 || reg_rji !== 10'h155) $display("FAIL ack_prep got d%b r%h want d1 r155", done, reg_rji); else n_pass++;
      ack = 1'b1; start = 1'b1; tick(); ack = 1'b0; start = 1'b0;
      n_checks += 3;
      if (busy !== 1'b1 || done !== 1'b0) $display("FAIL start_beats_ack got b%b d%b want b1 d0", busy, done); else n_pass++;
      if (reg_rji !== 10'h000) $display("FAIL start_beats_ack_reg got %h want 000", reg_rji); else n_pass++;
      if (iter_cnt !== 4'd0)   $display("FAIL start_beats_ack_cnt got %0d want 0", iter_cnt); else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst   = ($urandom_range(99) < 2);
         en    = ($urandom_range(99) < 75);
         start = ($urandom_range(99) < 6);
         ack   = ($urandom_range(99) < 30);
         rjo   = 11'($urandom);
         tick();
         n_checks += 4;
         if (reg_rji !== m_res)       $display("FAIL rand_reg c%0d got %h want %h", i, reg_rji, m_res); else n_pass++;
         if (iter_cnt !== 4'(m_cnt))  $display("FAIL rand_cnt c%0d got %0d want %0d", i, iter_cnt, m_cnt); else n_pass++;
         if (busy !== (m_phase == 1)) $display("FAIL rand_busy c%0d got %b want %b", i, busy, m_phase == 1); else n_pass++;
         if (done !== (m_phase == 2)) $display("FAIL rand_done c%0d got %b want %b", i, done, m_phase == 2); else n_pass++;
      end
      rst = 1'b0; en = 1'b1; start = 1'b0; ack = 1'b0;
   endtask

   task automatic test_shift2();
      rst_b = 1'b1; en_b = 1'b1; start_b = 1'b0; ack_b = 1'b0; rjo_b = '1;
      tick();
      rst_b = 1'b0; start_b = 1'b1; tick(); start_b = 1'b0;
      n_checks++;
      if (busy_b !== 1'b1) $display("FAIL s2_busy got %b want 1", busy_b); else n_pass++;
      rjo_b = 10'h3FC;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_checks += 4;
         if (reg_b !== 8'hFF)       $display("FAIL s2_reg it%0d got %h want ff", i, reg_b); else n_pass++;
         if (cnt_b !== 3'(i))       $display("FAIL s2_cnt it%0d got %0d want %0d", i, cnt_b, i); else n_pass++;
         if (done_b !== (i == 4))   $display("FAIL s2_done it%0d got %b want %b", i, done_b, i == 4); else n_pass++;
         if (busy_b !== (i < 4))    $display("FAIL s2_busy it%0d got %b want %b", i, busy_b, i < 4); else n_pass++;
      end
      start_b = 1'b1; tick(); start_b = 1'b0;
      rjo_b = 10'h2A9;
      tick(); tick();
      n_checks += 2;
      if (reg_b !== 8'hAA) $display("FAIL s2_reg_aa got %h want aa", reg_b); else n_pass++;
      if (cnt_b !== 3'd2)  $display("FAIL s2_cnt_2 got %0d want 2", cnt_b); else n_pass++;
      rst_b = 1'b1; tick(); rst_b = 1'b0;
      n_checks += 2;
      if (busy_b !== 1'b0 || done_b !== 1'b0) $display("FAIL s2_rst_flags got b%b d%b want b0 d0", busy_b, done_b); else n_pass++;
      if (reg_b !== 8'h00 || cnt_b !== 3'd0) $display("FAIL s2_rst_regs got r%h c%0d want r00 c0", reg_b, cnt_b); else n_pass++;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++;
         if (done_b !== 1'b0 || busy_b !== 1'b0) $display("FAIL s2_no_done c%0d got d%b b%b want d0 b0", i, done_b, busy_b); else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; start = 1'b0; ack = 1'b0; rjo = '0;
      rst_b = 1'b1; en_b = 1'b1; start_b = 1'b0; ack_b = 1'b0; rjo_b = '0;
      m_phase = 0; m_cnt = 0; m_res = '0;
      test_reset();
      test_full_run();
      test_en_stall();
      test_restart();
      test_ack();
      test_random();
      test_shift2();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
